// File: rtl/sram64_controller.sv
// Bridges a 32-bit pipeline data port to a 64-bit asynchronous SRAM.
// Reads wait a fixed number of cycles; writes are read-modify-write of the full line.
module sram64_controller #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int          RD_WAIT   = 2,
  parameter int          WR_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic [63:0] READ_LINE,
  output logic        READY,
  output logic        SRAM_WE_N,
  output logic [16:0] SRAM_ADDR,
  inout  wire  [63:0] SRAM_DQ
);

  localparam int CNT_MAX = (RD_WAIT > WR_CYCLES) ? RD_WAIT : WR_CYCLES;
  localparam int CNT_W   = ($clog2(CNT_MAX) > 3) ? $clog2(CNT_MAX) : 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR_RD  = 3'd2,
    WR_DRV = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             word_sel;
  logic [31:0]      wdata_q;
  logic [63:0]      merge_q;
  logic [31:0]      off;
  logic             req;
  logic             last_cnt;
  logic             unused_off;

  assign off        = ADDRESS - BASE_ADDR;
  assign req        = MEM_R_EN | MEM_W_EN;
  assign last_cnt   = (cnt == '0);
  assign unused_off = ^{off[31:19], off[1:0]};

  function automatic logic [31:0] select_word(input logic [63:0] line, input logic sel);
    return sel ? line[63:32] : line[31:0];
  endfunction

  function automatic logic [63:0] merge_word(input logic [63:0] line, input logic sel,
                                             input logic [31:0] w);
    return sel ? {w, line[31:0]} : {line[63:32], w};
  endfunction

  // Control path and architecturally visible registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_ADDR <= '0;
      READ_DATA <= '0;
      READ_LINE <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            SRAM_ADDR <= {off[18:3], 1'b0};
            cnt       <= CNT_W'(RD_WAIT - 1);
            state     <= MEM_W_EN ? WR_RD : RD;
          end
        end
        RD: begin
          if (last_cnt) begin
            READ_LINE <= SRAM_DQ;
            READ_DATA <= select_word(SRAM_DQ, word_sel);
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_RD: begin
          if (last_cnt) begin
            READ_LINE <= SRAM_DQ;
            SRAM_WE_N <= 1'b0;
            cnt       <= CNT_W'(WR_CYCLES - 1);
            state     <= WR_DRV;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_DRV: begin
          if (last_cnt) begin
            SRAM_WE_N <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request payload and merge line; no reset needed, always loaded before use
  always_ff @(posedge CLK) begin
    if (state == IDLE && req) begin
      word_sel <= off[2];
      wdata_q  <= WRITE_DATA;
    end
    if (state == WR_RD && last_cnt) begin
      merge_q <= merge_word(SRAM_DQ, word_sel, wdata_q);
    end
  end

  always_comb begin
    READY = 1'b0;
    case (state)
      IDLE:    READY = ~req;
      DONE:    READY = 1'b1;
      default: READY = 1'b0;
    endcase
  end

  // Driven only while WE_N is low; an async reset releases the bus at once
  assign SRAM_DQ = (state == WR_DRV) ? merge_q : 64'bz;

endmodule

// File: tb/tb_sram64_controller.sv
// Self-checking bench for sram64_controller with a word-level memory reference model.
module tb_sram64_controller;

  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_en, w_en;
  logic [31:0] address, write_data;
  wire  [31:0] read_data;
  wire  [63:0] read_line;
  wire         ready, sram_we_n;
  wire  [16:0] sram_addr;
  wire  [63:0] sram_dq;

  logic [63:0] mem [0:65535];
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [63:0] ld_data;

  int checks   = 0;
  int failures = 0;
  logic [63:0] ref_line [bit [15:0]];
  logic [31:0] last_rd;

  always #10 clk = ~clk;

  sram64_controller #(.BASE_ADDR(BASE), .RD_WAIT(2), .WR_CYCLES(2)) dut (
    .CLK(clk), .RST(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en),
    .ADDRESS(address), .WRITE_DATA(write_data),
    .READ_DATA(read_data), .READ_LINE(read_line), .READY(ready),
    .SRAM_WE_N(sram_we_n), .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq)
  );

  // Asynchronous SRAM: drives the line whenever WE_N is high, stores on clock edges while low
  assign sram_dq = sram_we_n ? mem[sram_addr[16:1]] : 64'bz;
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (!sram_we_n) mem[sram_addr[16:1]] <= sram_dq;
  end

  function automatic logic [15:0] dw_of(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o[18:3];
  endfunction

  function automatic logic ws_of(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o[2];
  endfunction

  function automatic logic [31:0] word_of(input logic [63:0] line, input logic ws);
    logic [31:0] w [2];
    w[0] = line[31:0];
    w[1] = line[63:32];
    return w[ws];
  endfunction

  function automatic logic [63:0] put_word(input logic [63:0] line, input logic ws,
                                           input logic [31:0] d);
    logic [31:0] w [2];
    w[0] = line[31:0];
    w[1] = line[63:32];
    w[ws] = d;
    return {w[1], w[0]};
  endfunction

  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] wd, input bit drop,
                        output int stalls, output int wes, output logic [16:0] addr_seen,
                        output logic [16:0] we_addr, output logic [63:0] dq_last);
    bit got;
    got = 0; stalls = 0; wes = 0; addr_seen = '0; we_addr = '0; dq_last = '0;
    @(negedge clk);
    address = a; write_data = wd; w_en = wr; r_en = rd;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (ready) begin got = 1; break; end
      stalls++;
      if (cyc == 1) addr_seen = sram_addr;
      if (!sram_we_n) begin wes++; we_addr = sram_addr; dq_last = sram_dq; end
      @(negedge clk);
      if (drop) begin w_en = 0; r_en = 0; end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL access_timeout addr=%h stalls=%0d required READY within 20 cycles", a, stalls);
    end
    @(posedge clk);
    #1;
    w_en = 0; r_en = 0;
  endtask

  task automatic preload();
    bit [15:0] keys [$];
    for (int i = 0; i < 32; i++) keys.push_back(16'(i));
    keys.push_back(16'd40);
    keys.push_back(16'hFFFF);
    ld_en = 1;
    foreach (keys[i]) begin
      @(negedge clk);
      ld_addr = keys[i];
      ld_data = {$urandom, $urandom};
      ref_line[keys[i]] = ld_data;
    end
    @(negedge clk);
    ld_en = 0;
  endtask

  task automatic test_reset();
    rst = 1; r_en = 0; w_en = 0; address = '0; write_data = '0;
    preload();
    @(negedge clk);
    rst = 0;
    #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL reset_we_n got=%b exp=1", sram_we_n); end
    checks++; if (sram_addr !== 17'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", sram_addr); end
    checks++; if (sram_dq !== ref_line[16'd0]) begin failures++; $display("FAIL reset_dq_released got=%h exp=%h", sram_dq, ref_line[16'd0]); end
    checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL reset_read_data got=%h exp=0", read_data); end
    checks++; if (read_line !== 64'h0) begin failures++; $display("FAIL reset_read_line got=%h exp=0", read_line); end
    last_rd = 32'h0;
  endtask

  task automatic test_write_read();
    int st, we; logic [16:0] as, wa; logic [63:0] dq, exp_line;
    exp_line = put_word(ref_line[16'd0], 1'b0, 32'h11223344);
    access(1, 0, 32'd1024, 32'h11223344, 0, st, we, as, wa, dq);
    checks++; if (st != 5) begin failures++; $display("FAIL wr_stalls got=%0d exp=5", st); end
    checks++; if (we != 2) begin failures++; $display("FAIL wr_we_cycles got=%0d exp=2", we); end
    checks++; if (wa !== 17'h0) begin failures++; $display("FAIL wr_addr got=%h exp=0", wa); end
    checks++; if (dq !== exp_line) begin failures++; $display("FAIL wr_dq got=%h exp=%h", dq, exp_line); end
    checks++; if (read_data !== last_rd) begin failures++; $display("FAIL wr_read_data_kept got=%h exp=%h", read_data, last_rd); end
    ref_line[16'd0] = exp_line;
    access(0, 1, 32'd1024, 32'h0, 0, st, we, as, wa, dq);
    checks++; if (st != 3) begin failures++; $display("FAIL rd_stalls got=%0d exp=3", st); end
    checks++; if (we != 0) begin failures++; $display("FAIL rd_we_cycles got=%0d exp=0", we); end
    checks++; if (read_data !== 32'h11223344) begin failures++; $display("FAIL rd_data got=%h exp=11223344", read_data); end
    last_rd = 32'h11223344;
  endtask

  task automatic test_rmw();
    int st, we; logic [16:0] as, wa; logic [63:0] dq;
    access(1, 0, 32'd1028, 32'hAABBCCDD, 0, st, we, as, wa, dq);
    checks++; if (read_line !== ref_line[16'd0]) begin failures++; $display("FAIL rmw_fetch_line got=%h exp=%h", read_line, ref_line[16'd0]); end
    ref_line[16'd0] = put_word(ref_line[16'd0], 1'b1, 32'hAABBCCDD);
    access(0, 1, 32'd1024, 32'h0, 0, st, we, as, wa, dq);
    checks++; if (read_data !== 32'h11223344) begin failures++; $display("FAIL rmw_word0 got=%h exp=11223344", read_data); end
    checks++; if (read_line !== 64'hAABBCCDD_11223344) begin failures++; $display("FAIL rmw_line got=%h exp=aabbccdd11223344", read_line); end
    last_rd = 32'h11223344;
  endtask

  task automatic test_addr_map();
    int st, we; logic [16:0] as, wa; logic [63:0] dq;
    logic [31:0] addrs [4];
    addrs[0] = 32'd1032; addrs[1] = 32'd1027; addrs[2] = BASE - 32'd8; addrs[3] = BASE - 32'd4;
    foreach (addrs[i]) begin
      access(0, 1, addrs[i], 32'h0, 0, st, we, as, wa, dq);
      checks++;
      if (as !== {dw_of(addrs[i]), 1'b0}) begin
        failures++; $display("FAIL map_addr a=%0d got=%h exp=%h", addrs[i], as, {dw_of(addrs[i]), 1'b0});
      end
      checks++;
      if (read_data !== word_of(ref_line[dw_of(addrs[i])], ws_of(addrs[i]))) begin
        failures++; $display("FAIL map_data a=%0d got=%h exp=%h", addrs[i], read_data,
                             word_of(ref_line[dw_of(addrs[i])], ws_of(addrs[i])));
      end
      last_rd = read_data;
    end
    checks++; if (as !== 17'h1FFFE) begin failures++; $display("FAIL map_wrap got=%h exp=1fffe", as); end
  endtask

  task automatic test_both_en();
    int st, we; logic [16:0] as, wa; logic [63:0] dq;
    access(1, 1, 32'd1040, 32'hDEADBEEF, 0, st, we, as, wa, dq);
    checks++; if (st != 5) begin failures++; $display("FAIL both_stalls got=%0d exp=5", st); end
    checks++; if (we != 2) begin failures++; $display("FAIL both_we_cycles got=%0d exp=2", we); end
    ref_line[16'd2] = put_word(ref_line[16'd2], 1'b0, 32'hDEADBEEF);
    access(0, 1, 32'd1040, 32'h0, 0, st, we, as, wa, dq);
    checks++; if (read_data !== 32'hDEADBEEF) begin failures++; $display("FAIL both_read got=%h exp=deadbeef", read_data); end
    last_rd = 32'hDEADBEEF;
  endtask

  task automatic test_reset_mid_write();
    int nwe, st, we; logic [16:0] as, wa; logic [63:0] dq; logic [31:0] a;
    nwe = 0;
    @(negedge clk);
    address = BASE + 32'd324; write_data = $urandom; w_en = 1; r_en = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (!sram_we_n) nwe++;
      if (nwe == 2) break;
      @(negedge clk);
    end
    checks++; if (nwe != 2) begin failures++; $display("FAIL rst_mid_reach got=%0d exp=2", nwe); end
    rst = 1; w_en = 0;
    #1;
    checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL rst_mid_we_n got=%b exp=1", sram_we_n); end
    checks++; if (sram_addr !== 17'h0) begin failures++; $display("FAIL rst_mid_addr got=%h exp=0", sram_addr); end
    checks++; if (sram_dq !== ref_line[16'd0]) begin failures++; $display("FAIL rst_mid_dq got=%h exp=%h", sram_dq, ref_line[16'd0]); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", ready); end
    checks++; if (read_line !== 64'h0) begin failures++; $display("FAIL rst_mid_line got=%h exp=0", read_line); end
    @(negedge clk);
    rst = 0;
    last_rd = 32'h0;
    a = BASE + 32'($urandom_range(0, 31) * 8) + 32'($urandom_range(0, 1) * 4);
    access(0, 1, a, 32'h0, 0, st, we, as, wa, dq);
    checks++; if (st != 3) begin failures++; $display("FAIL rst_mid_rd_stalls got=%0d exp=3", st); end
    checks++;
    if (read_data !== word_of(ref_line[dw_of(a)], ws_of(a))) begin
      failures++; $display("FAIL rst_mid_rd_data got=%h exp=%h", read_data, word_of(ref_line[dw_of(a)], ws_of(a)));
    end
    last_rd = read_data;
  endtask

  task automatic test_random();
    int st, we; logic [16:0] as, wa; logic [63:0] dq, old;
    logic [31:0] a, d; bit wr, rd, drop; logic [15:0] k; logic ws;
    for (int n = 0; n < 40; n++) begin
      a = BASE + 32'($urandom_range(0, 31) * 8) + 32'($urandom_range(0, 7));
      d = $urandom;
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      drop = ($urandom_range(0, 3) == 0);
      k = dw_of(a); ws = ws_of(a); old = ref_line[k];
      access(wr, rd, a, d, drop, st, we, as, wa, dq);
      checks++;
      if (st != (wr ? 5 : 3)) begin failures++; $display("FAIL rnd_stalls n=%0d got=%0d exp=%0d", n, st, wr ? 5 : 3); end
      checks++;
      if (read_line !== old) begin failures++; $display("FAIL rnd_line n=%0d got=%h exp=%h", n, read_line, old); end
      if (wr) begin
        ref_line[k] = put_word(old, ws, d);
        checks++;
        if (dq !== ref_line[k] || wa !== {k, 1'b0}) begin
          failures++; $display("FAIL rnd_write n=%0d dq=%h addr=%h exp dq=%h addr=%h", n, dq, wa, ref_line[k], {k, 1'b0});
        end
      end else begin
        last_rd = word_of(old, ws);
      end
      checks++;
      if (read_data !== last_rd) begin failures++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, read_data, last_rd); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    ld_en = 0; ld_addr = '0; ld_data = '0;
    test_reset();
    test_write_read();
    test_rmw();
    test_addr_map();
    test_both_en();
    test_reset_mid_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram64_controller.md
Name: sram64_controller

Overview:
- Bridges the 32-bit MEM-stage data port of the ARM pipeline to the 64-bit asynchronous SRAM model.
- Reads take a fixed number of wait states; 32-bit writes are read-modify-write onto the 64-bit line.
- READY stalls the pipeline while an access is in flight.
- READ_LINE exposes the full 64-bit doubleword for a downstream line cache.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM doubleword 0.
- RD_WAIT, 2: cycles SRAM_ADDR is held before DQ is sampled (≥30 ns at the 20 ns clock).
- WR_CYCLES, 2: consecutive cycles SRAM_WE_N is held low with stable address/data.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  asynchronous, active-high reset.
- MEM_R_EN  in  1  read request; held stable until READY=1.
- MEM_W_EN  in  1  write request; held stable until READY=1; wins over MEM_R_EN if both are high.
- ADDRESS  in  32  byte address.
- WRITE_DATA  in  32  write word.
- READ_DATA  out  32  selected word of the last read; registered.
- READ_LINE  out  64  full doubleword of the last read or RMW fetch; registered.
- READY  out  1  1 = no access in progress, or access completes this cycle.
- SRAM_WE_N  out  1  SRAM write enable, active-low; registered.
- SRAM_ADDR  out  17  SRAM address; registered.
- SRAM_DQ  inout  64  SRAM data; driven only in WR_DRV, otherwise high-Z.

Behaviour:
- Address mapping
  - off = ADDRESS - BASE_ADDR, in 32-bit unsigned arithmetic, wrapping.
  - Doubleword index = off[18:3]; word select = off[2]; off[1:0] ignored.
  - SRAM_ADDR = {off[18:3], 1'b0}, latched at request acceptance.
  - Word 0 = DQ[31:0]; word 1 = DQ[63:32].
- States: IDLE, RD, WR_RD, WR_DRV, DONE. State is 3-bit; wait counter is ≥3 bits.
- IDLE
  - READY = ~(MEM_R_EN | MEM_W_EN), combinational.
  - On request: latch address, word select and WRITE_DATA; load counter.
  - Go to WR_RD if MEM_W_EN is high, else RD.
- RD
  - Holds SRAM_WE_N=1 and the address for RD_WAIT cycles.
  - On the edge ending the last cycle: READ_LINE <= SRAM_DQ; READ_DATA <= selected word; go to DONE.
  - Read costs 1+RD_WAIT cycles with READY=0 (3 by default).
- WR_RD
  - Same timing as RD; captures the line into READ_LINE.
  - The merge register is the line with the selected word replaced by WRITE_DATA.
  - READ_DATA is unchanged. Then go to WR_DRV.
- WR_DRV
  - SRAM_WE_N=0 and SRAM_DQ = merged line for WR_CYCLES cycles; address unchanged.
  - Only the last write edge's content must be correct, because the SRAM releases DQ with a 30 ns delay.
  - SRAM_WE_N returns to 1 and DQ goes high-Z in the same cycle the FSM enters DONE.
  - Write costs 1+RD_WAIT+WR_CYCLES cycles with READY=0 (5 by default).
- DONE
  - READY=1 for exactly one cycle; the pipeline advances on this edge.
  - Unconditionally return to IDLE; a request seen in IDLE next cycle is a new access.
- Request drop
  - If the request is deasserted mid-access, the access still completes.
  - A started write always commits.
- Reset (async, any state)
  - state=IDLE, counter=0, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ=Z, READ_DATA=0, READ_LINE=0.
  - READY then follows the IDLE equation.
  - A write interrupted by reset may leave the line corrupt; this is acceptable.
- SRAM_DQ is never driven while SRAM_WE_N=1 from the controller's side.
- No back-to-back accept: at least one IDLE cycle always separates accesses.

Test Plan:
- Reset, no requests -> READY=1, SRAM_WE_N=1, SRAM_ADDR=0, DQ=Z, READ_DATA=0, READ_LINE=0.
- Write 0x11223344 to ADDRESS=1024 -> READY low 5 cycles; SRAM_WE_N low 2 cycles at SRAM_ADDR=0; then read of 1024 returns READ_DATA=0x11223344 after 3 stalled cycles.
- Write 0xAABBCCDD to 1028, then read 1024 -> READ_DATA=0x11223344, READ_LINE=0xAABBCCDD_11223344 (RMW preserved the other word).
- Read ADDRESS=1032 -> SRAM_ADDR=17'h2; ADDRESS=1027 maps to word 0 of dword 0 (off[1:0] ignored).
- MEM_R_EN and MEM_W_EN both high with 0xDEADBEEF at 1040 -> write path taken (5 cycles); subsequent read of 1040 = 0xDEADBEEF.
- Assert RST in the second WR_DRV cycle -> SRAM_WE_N=1 and DQ=Z immediately (before next edge), state IDLE; a following read completes normally in 3 cycles.
